// File: rtl/dpram_pkg.sv
// Shared types and sizing helpers for the dual-port RAM burst reader.
package dpram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;

  // Counters need one extra bit so a full-memory burst length fits.
  function automatic int count_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry registered FIFO; head entry drives dout directly so output is glitch-free.
module sync_fifo2
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_count;
  logic                  w_pop;
  logic                  w_push;

  assign w_pop  = pop && (r_count != 2'd0);
  // A push into a full FIFO is only legal when the same cycle frees a slot.
  assign w_push = push && ((r_count != 2'(FIFO_DEPTH)) || w_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= din;
          end else begin
            r_head <= r_tail;
            r_tail <= din;
          end
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b10: begin
          if (r_count == 2'd0) r_head <= din;
          else                 r_tail <= din;
          r_count <= r_count + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign dout  = r_head;
  assign count = r_count;

endmodule

// File: rtl/dpram_burst_reader.sv
// Burst read client for one RAM port: streams `length` words from `base_addr`
// through a 2-entry buffer that hides the registered-read latency.
module dpram_burst_reader
  import dpram_pkg::*;
#(
  parameter int widthad_a  = 15,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [widthad_a-1:0]  base_addr,
  input  logic [widthad_a:0]    length,
  output logic                  busy,
  output logic                  done,
  output logic [widthad_a-1:0]  mem_address,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            dbg_state
);

  localparam int CW = count_width(widthad_a);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [widthad_a-1:0] r_addr;
  logic [CW-1:0]        r_remaining;
  logic [CW-1:0]        r_delivered;
  logic                 r_inflight;
  logic                 r_done;
  logic [1:0]           w_occ;
  logic                 w_pop;
  logic                 w_issue;
  logic                 w_accept;
  logic                 w_last_pop;

  // Stream handshake: a word moves when out_valid & out_ready; out_valid and
  // out_data stay put until that happens.
  assign w_pop      = out_valid & out_ready;
  assign out_valid  = (w_occ != 2'd0);
  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_last_pop = w_pop && (r_delivered == CW'(1));
  // Buffer plus in-flight word must not exceed the depth after this cycle.
  assign w_issue    = (r_state == ST_RUN) && (r_remaining != '0) &&
                      (({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start && (length != '0)) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_last_pop)                                  w_state_nxt = ST_IDLE;
        else if (w_issue && (r_remaining == CW'(1)))     w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (w_last_pop) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_delivered <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done     <= (w_accept && (length == '0)) || ((r_state != ST_IDLE) && w_last_pop);
      r_inflight <= w_issue;
      if (w_accept) begin
        if (length != '0) begin
          r_addr      <= base_addr;
          r_remaining <= length;
          r_delivered <= length;
        end
      end else begin
        if (w_issue) begin
          r_addr      <= r_addr + widthad_a'(1);
          r_remaining <= r_remaining - CW'(1);
        end
        if (w_pop) r_delivered <= r_delivered - CW'(1);
      end
    end
  end

  sync_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (r_inflight),
    .pop  (w_pop),
    .din  (mem_q),
    .dout (out_data),
    .count(w_occ)
  );

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign mem_address = r_addr;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Bench for dpram_burst_reader: RAM model, vector table of bursts, scoreboard on the stream.
module tb_dpram_burst_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [14:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [14:0] mem_address;
  logic [7:0]  mem_q;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  dbg_state;

  logic [7:0]  ram [0:32767];
  logic [7:0]  exp_q [$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ready_mode = 0;
  int pops = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;
  logic [7:0]  first_data;
  logic [14:0] b_base = '0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data;
  logic [14:0] prev_addr;
  int          prev_est = 0;

  typedef struct {
    logic [14:0] base;
    logic [15:0] len;
    int          mode;
    int          glitch;
    logic [7:0]  exp_first;
  } vec_t;
  vec_t vecs [8];

  dpram_burst_reader #(.widthad_a(15), .DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .mem_address(mem_address),
    .mem_q(mem_q), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  always @(posedge clock) mem_q <= ram[mem_address];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  always @(negedge clock) begin
    logic [14:0] adv;
    int          est;
    if (!reset) begin
      adv = mem_address - b_base;
      est = int'(adv) - pops;
      if (busy) begin
        check("occupancy_bound", est <= 2, 1);
        if (prev_stall && prev_est == 2) check("addr_hold_stall", mem_address, prev_addr);
      end
      if (prev_stall) begin
        check("valid_held", out_valid, 1);
        check("data_stable", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        check("exp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("stream_data", out_data, exp_q.pop_front());
        if (pops == 0) begin
          first_pop_cyc = cyc;
          first_data    = out_data;
        end
        last_pop_cyc = cyc;
        pops++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_addr  = mem_address;
      prev_est   = busy ? est : 0;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic load_expect(input logic [14:0] base, input logic [15:0] len);
    logic [14:0] a;
    for (int i = 0; i < int'(len); i++) begin
      a = base + 15'(i);
      exp_q.push_back(ram[a]);
    end
    pops   = 0;
    b_base = base;
  endtask

  task automatic run_burst(input logic [14:0] base, input logic [15:0] len, input int mode,
                           input int glitch, input logic [7:0] exp_first);
    int n;
    bit seen_done;
    ready_mode = mode;
    load_expect(base, len);
    start = 1'b1; base_addr = base; length = len;
    step();
    start = 1'b0;
    if (len == 16'd0) begin
      check("len0_done", done, 1);
      check("len0_busy", busy, 0);
      step();
      check("len0_done_pulse", done, 0);
      repeat (3) step();
      check("len0_busy_after", busy, 0);
      check("len0_no_words", pops, 0);
      return;
    end
    check("start_busy", busy, 1);
    check("start_addr", mem_address, base);
    check("start_valid", out_valid, 0);
    step();
    check("lat_e1_valid", out_valid, 0);
    step();
    check("lat_e2_valid", out_valid, 1);
    seen_done = 1'b0;
    n = 0;
    while (!seen_done && n < 40000) begin
      if (done) begin
        seen_done = 1'b1;
      end else begin
        if (glitch != 0 && n == glitch) begin
          start = 1'b1; base_addr = 15'h0300; length = 16'd3;
        end
        step();
        start = 1'b0;
        n++;
      end
    end
    check("done_seen", seen_done, 1);
    check("done_timing", cyc, last_pop_cyc + 1);
    check("done_busy_low", busy, 0);
    check("word_count", pops, len);
    check("exp_q_drained", exp_q.size(), 0);
    check("first_word", first_data, exp_first);
    if (mode == 0) check("throughput", last_pop_cyc - first_pop_cyc, int'(len) - 1);
    step();
    check("done_one_cycle", done, 0);
    check("idle_after", busy, 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32768; i++) ram[i] = i[7:0];
    vecs[0] = '{15'h0010, 16'd4,  0, 0, 8'h10};
    vecs[1] = '{15'h0040, 16'd8,  1, 0, 8'h40};
    vecs[2] = '{15'h7FFE, 16'd4,  0, 0, 8'hFE};
    vecs[3] = '{15'h0000, 16'd0,  0, 0, 8'h00};
    vecs[4] = '{15'h0200, 16'd6,  1, 5, 8'h00};
    vecs[5] = '{15'h1234, 16'd20, 2, 0, 8'h34};
    vecs[6] = '{15'h0005, 16'd1,  0, 0, 8'h05};
    vecs[7] = '{15'h0377, 16'd3,  2, 0, 8'h77};

    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_addr", mem_address, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    step();

    for (int v = 0; v < 8; v++)
      run_burst(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].glitch, vecs[v].exp_first);

    // Abort a burst part-way through, then confirm a fresh burst is clean.
    ready_mode = 0;
    load_expect(15'h0020, 16'd16);
    start = 1'b1; base_addr = 15'h0020; length = 16'd16;
    step();
    start = 1'b0;
    n = 0;
    while (pops < 5 && n < 100) begin
      step();
      n++;
    end
    check("rst_mid_pops_reached", pops >= 5, 1);
    reset = 1'b1;
    step();
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_done", done, 0);
    reset = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      step();
      check("rst_mid_no_done", done, 0);
      check("rst_mid_no_valid", out_valid, 0);
    end
    run_burst(15'h0100, 16'd2, 0, 0, 8'h00);

    run_burst(15'h1234, 16'h8000, 0, 0, 8'h34);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
